// File: rtl/tiny16_pkg.sv
// tiny16_pkg: opcode, instruction-field and FSM definitions shared by the tiny16 issue stage.
package tiny16_pkg;

    localparam int REG_COUNT = 8;
    localparam int XLEN      = 16;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int AR_BIT  = 2;

    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;

    typedef logic state_t;
    localparam state_t ST_EMPTY = 1'b0;
    localparam state_t ST_HELD  = 1'b1;

    function automatic logic [3:0] instr_opcode(input logic [XLEN-1:0] i);
        return i[OPC_LSB +: 4];
    endfunction

    function automatic logic [2:0] instr_rd(input logic [XLEN-1:0] i);
        return i[RD_LSB +: 3];
    endfunction

    function automatic logic [2:0] instr_rs1(input logic [XLEN-1:0] i);
        return i[RS1_LSB +: 3];
    endfunction

    function automatic logic [2:0] instr_rs2(input logic [XLEN-1:0] i);
        return i[RS2_LSB +: 3];
    endfunction

    function automatic logic instr_ar(input logic [XLEN-1:0] i);
        return i[AR_BIT];
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_MOV, OP_SHL, OP_SHR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tiny16_regfile.sv
// tiny16_regfile: 8x16 register file, two asynchronous reads, one synchronous write, r0 hardwired to 0.
module tiny16_regfile
    import tiny16_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [2:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [2:0]      raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem_q [REG_COUNT];

    // NOTE: this array is reset on purpose - every entry must read 0 straight out of reset,
    // which rules out RAM macros; a plain storage array would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) mem_q[i] <= '0;
        end else if (we && waddr != '0) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-entry hold register plus scoreboard issuing operations to the tiny16 ALU.
// Define ALU_ISSUE_BYPASS_EN to let a same-cycle writeback clear hazards and forward its data.
module alu_issue
    import tiny16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic [3:0]  opcode,
    output logic        ar_flag,
    output logic [15:0] src1,
    output logic [15:0] src2,
    output logic [2:0]  dest,
    output logic        out_en,
    output logic        err_illegal
);

    state_t               state_q, state_d;
    logic [XLEN-1:0]      hold_q, hold_d;
    logic [REG_COUNT-1:0] pending_q, pending_d;
    logic [3:0]           opcode_q, opcode_d;
    logic                 ar_flag_q, ar_flag_d;
    logic [XLEN-1:0]      src1_q, src1_d;
    logic [XLEN-1:0]      src2_q, src2_d;
    logic [2:0]           dest_q, dest_d;
    logic                 out_en_q, out_en_d;
    logic                 err_illegal_q, err_illegal_d;

    logic [3:0]           h_op;
    logic [2:0]           h_rd, h_rs1, h_rs2;
    logic                 h_ar;
    logic [XLEN-1:0]      rf_rdata1, rf_rdata2, opnd1, opnd2;
    logic [REG_COUNT-1:0] wb_mask, byp_mask, pend_eff;
    logic                 hazard;
    logic                 unused_rsvd;

    assign h_op        = instr_opcode(hold_q);
    assign h_rd        = instr_rd(hold_q);
    assign h_rs1       = instr_rs1(hold_q);
    assign h_rs2       = instr_rs2(hold_q);
    assign h_ar        = instr_ar(hold_q);
    assign unused_rsvd = ^hold_q[1:0];

    tiny16_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (h_rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (h_rs2),
        .rdata2 (rf_rdata2)
    );

    // r0 is excluded here so it can never be pending nor forwarded.
    assign wb_mask = (wb_en && wb_addr != '0) ? (REG_COUNT'(1) << wb_addr) : '0;

`ifdef ALU_ISSUE_BYPASS_EN
    assign byp_mask = wb_mask;
`else
    assign byp_mask = '0;
`endif

    assign pend_eff    = pending_q & ~byp_mask;
    assign hazard      = pend_eff[h_rs1] | pend_eff[h_rs2] | pend_eff[h_rd];
    assign opnd1       = byp_mask[h_rs1] ? wb_data : rf_rdata1;
    assign opnd2       = byp_mask[h_rs2] ? wb_data : rf_rdata2;
    assign instr_ready = (state_q == ST_EMPTY);

    always_comb begin
        // NOTE: every *_d gets a default before any branch, so no path can infer a latch.
        state_d       = state_q;
        hold_d        = hold_q;
        pending_d     = pending_q & ~wb_mask;
        opcode_d      = opcode_q;
        ar_flag_d     = ar_flag_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        dest_d        = dest_q;
        out_en_d      = 1'b0;
        err_illegal_d = 1'b0;

        if (state_q == ST_EMPTY) begin
            if (instr_valid) begin
                hold_d  = instr;
                state_d = ST_HELD;
            end
        end else if (flush) begin
            state_d = ST_EMPTY;
        end else if (!hazard) begin
            state_d = ST_EMPTY;
            if (is_alu_op(h_op)) begin
                opcode_d  = h_op;
                ar_flag_d = h_ar;
                src1_d    = opnd1;
                src2_d    = opnd2;
                dest_d    = h_rd;
                out_en_d  = 1'b1;
                // Applied after the writeback clear so a same-edge set of rd wins.
                if (h_rd != '0) pending_d[h_rd] = 1'b1;
            end else begin
                err_illegal_d = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only; blocking here would
    // let later statements observe this edge's new values and create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            hold_q        <= '0;
            pending_q     <= '0;
            opcode_q      <= '0;
            ar_flag_q     <= 1'b0;
            src1_q        <= '0;
            src2_q        <= '0;
            dest_q        <= '0;
            out_en_q      <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            pending_q     <= pending_d;
            opcode_q      <= opcode_d;
            ar_flag_q     <= ar_flag_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            dest_q        <= dest_d;
            out_en_q      <= out_en_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign opcode      = opcode_q;
    assign ar_flag     = ar_flag_q;
    assign src1        = src1_q;
    assign src2        = src2_q;
    assign dest        = dest_q;
    assign out_en      = out_en_q;
    assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed table, hand-written hazard/flush/reset sequences and random
// stimulus for alu_issue, each cycle compared against a behavioural model.
module tb_alu_issue;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [42:0] RESET_VEC = {3'b001, 40'd0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  opcode;
    logic        ar_flag;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [2:0]  dest;
    logic        out_en;
    logic        err_illegal;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .opcode      (opcode),
        .ar_flag     (ar_flag),
        .src1        (src1),
        .src2        (src2),
        .dest        (dest),
        .out_en      (out_en),
        .err_illegal (err_illegal)
    );

    // Behavioural model state.
    logic [15:0] m_rf [8];
    bit          m_pend [8];
    bit          m_held;
    logic [15:0] m_instr;
    logic [3:0]  m_op;
    bit          m_ar;
    logic [15:0] m_s1, m_s2;
    logic [2:0]  m_dest;
    bit          m_oe, m_err;

    typedef struct {
        logic [15:0] instr;
        logic        out_en;
        logic        err;
        logic [3:0]  op;
        logic        ar;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [2:0]  dest;
    } vec_t;

    vec_t        vecs [9];
    logic [15:0] pre [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1,
                                        input int rs2, input int ar, input int rsv);
        return 16'((op << 12) | (rd << 9) | (rs1 << 6) | (rs2 << 3) | (ar << 2) | rsv);
    endfunction

    function automatic logic [42:0] dut_vec();
        return {out_en, err_illegal, instr_ready, opcode, ar_flag, dest, src1, src2};
    endfunction

    function automatic logic [42:0] exp_vec();
        return {m_oe, m_err, !m_held, m_op, m_ar, m_dest, m_s1, m_s2};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            m_rf[r]   = 16'h0;
            m_pend[r] = 1'b0;
        end
        m_held = 1'b0; m_instr = 16'h0;
        m_op = 4'h0; m_ar = 1'b0; m_s1 = 16'h0; m_s2 = 16'h0; m_dest = 3'd0;
        m_oe = 1'b0; m_err = 1'b0;
    endtask

    // One rising edge of the issue stage, applied with the inputs currently driven.
    task automatic model_edge();
        bit         fwd [8];
        bit         blocked;
        int         op;
        logic [2:0] rd, rs1, rs2;
        int         set_rd;
        set_rd = 0;
        for (int r = 0; r < 8; r++)
            fwd[r] = BYPASS && wb_en && (wb_addr == 3'(r)) && (r != 0);
        m_oe = 1'b0;
        m_err = 1'b0;
        if (!m_held) begin
            if (instr_valid) begin
                m_held  = 1'b1;
                m_instr = instr;
            end
        end else if (flush) begin
            m_held = 1'b0;
        end else begin
            op  = int'(m_instr[15:12]);
            rd  = m_instr[11:9];
            rs1 = m_instr[8:6];
            rs2 = m_instr[5:3];
            blocked = (m_pend[rs1] && !fwd[rs1]) || (m_pend[rs2] && !fwd[rs2]) ||
                      (m_pend[rd] && !fwd[rd]);
            if (!blocked) begin
                m_held = 1'b0;
                if (op >= 3 && op <= 11) begin
                    m_oe   = 1'b1;
                    m_op   = m_instr[15:12];
                    m_ar   = m_instr[2];
                    m_dest = rd;
                    m_s1   = (rs1 == 3'd0) ? 16'h0 : (fwd[rs1] ? wb_data : m_rf[rs1]);
                    m_s2   = (rs2 == 3'd0) ? 16'h0 : (fwd[rs2] ? wb_data : m_rf[rs2]);
                    set_rd = int'(rd);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (wb_en && wb_addr != 3'd0) begin
            m_rf[wb_addr]   = wb_data;
            m_pend[wb_addr] = 1'b0;
        end
        if (set_rd != 0) m_pend[set_rd] = 1'b1;
    endtask

    task automatic cyc(input logic [15:0] i, input logic v, input logic f,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd);
        instr = i; instr_valid = v; flush = f; wb_en = we; wb_addr = wa; wb_data = wd;
        @(posedge clk);
        model_edge();
        #1;
        check("model", 64'(dut_vec()), 64'(exp_vec()));
    endtask

    task automatic idle();
        cyc(16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        lat = BYPASS ? 0 : 1;
        pre = '{16'h0000, 16'h0005, 16'h0003, 16'h0000, 16'h00A0, 16'hFFFF, 16'h1234, 16'h8000};
        vecs[0] = '{enc(3, 3, 1, 2, 0, 0),  1'b1, 1'b0, 4'h3, 1'b0, 16'h0005, 16'h0003, 3'd3};
        vecs[1] = '{enc(11, 7, 6, 5, 1, 3), 1'b1, 1'b0, 4'hB, 1'b1, 16'h1234, 16'hFFFF, 3'd7};
        vecs[2] = '{enc(4, 0, 0, 4, 0, 0),  1'b1, 1'b0, 4'h4, 1'b0, 16'h0000, 16'h00A0, 3'd0};
        vecs[3] = '{enc(2, 1, 1, 1, 0, 0),  1'b0, 1'b1, 4'h4, 1'b0, 16'h0000, 16'h00A0, 3'd0};
        vecs[4] = '{enc(12, 2, 2, 2, 1, 0), 1'b0, 1'b1, 4'h4, 1'b0, 16'h0000, 16'h00A0, 3'd0};
        vecs[5] = '{enc(0, 0, 0, 0, 0, 0),  1'b0, 1'b1, 4'h4, 1'b0, 16'h0000, 16'h00A0, 3'd0};
        vecs[6] = '{enc(7, 5, 7, 7, 0, 0),  1'b1, 1'b0, 4'h7, 1'b0, 16'h8000, 16'h8000, 3'd5};
        vecs[7] = '{enc(9, 6, 2, 4, 1, 2),  1'b1, 1'b0, 4'h9, 1'b1, 16'h0003, 16'h00A0, 3'd6};
        vecs[8] = '{enc(15, 3, 3, 3, 1, 3), 1'b0, 1'b1, 4'h9, 1'b1, 16'h0003, 16'h00A0, 3'd6};

        rst_n = 1'b0;
        instr = 16'h0; instr_valid = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
        model_reset();
        #3;
        check("reset_state", 64'(dut_vec()), 64'(RESET_VEC));
        #9 rst_n = 1'b1;

        // Preload; the r0 write must be ignored.
        cyc(16'h0, 1'b0, 1'b0, 1'b1, 3'd0, 16'hDEAD);
        for (int r = 1; r < 8; r++) cyc(16'h0, 1'b0, 1'b0, 1'b1, 3'(r), pre[r]);

        // Table: accept, expect issue (or illegal drop) one cycle later.
        for (int k = 0; k < 9; k++) begin
            cyc(vecs[k].instr, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
            check("tbl_ready_low", 64'(instr_ready), 64'(0));
            idle();
            check("tbl_out_en", 64'(out_en), 64'(vecs[k].out_en));
            check("tbl_err", 64'(err_illegal), 64'(vecs[k].err));
            check("tbl_opcode", 64'(opcode), 64'(vecs[k].op));
            check("tbl_ar", 64'(ar_flag), 64'(vecs[k].ar));
            check("tbl_src1", 64'(src1), 64'(vecs[k].s1));
            check("tbl_src2", 64'(src2), 64'(vecs[k].s2));
            check("tbl_dest", 64'(dest), 64'(vecs[k].dest));
            check("tbl_ready_high", 64'(instr_ready), 64'(1));
            if (vecs[k].out_en && vecs[k].dest != 3'd0)
                cyc(16'h0, 1'b0, 1'b0, 1'b1, vecs[k].dest, pre[vecs[k].dest]);
            idle();
            check("tbl_pulse_end", 64'({out_en, err_illegal}), 64'(0));
        end

        // RAW hazard on r3 released by writeback of 0x0008.
        cyc(enc(3, 3, 1, 2, 0, 0), 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        idle();
        check("raw_first_issue", 64'(out_en), 64'(1));
        cyc(enc(4, 4, 3, 1, 0, 0), 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            idle();
            check("raw_stalled", 64'({out_en, instr_ready}), 64'(0));
        end
        cyc(16'h0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0008);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) idle();
            check("raw_out_en", 64'(out_en), 64'(k == lat));
            if (k == lat) begin
                check("raw_src1", 64'(src1), 64'(16'h0008));
                check("raw_src2", 64'(src2), 64'(16'h0005));
                check("raw_dest", 64'(dest), 64'(3'd4));
            end
        end
        pre[3] = 16'h0008;
        cyc(16'h0, 1'b0, 1'b0, 1'b1, 3'd4, pre[4]);

        // Flush of a hazarded instruction, then accept while flush is still high.
        cyc(enc(3, 3, 1, 2, 0, 0), 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        idle();
        cyc(enc(5, 2, 3, 3, 0, 0), 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        idle();
        check("flush_held", 64'({out_en, instr_ready}), 64'(0));
        cyc(enc(6, 1, 1, 2, 0, 0), 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
        check("flush_empty", 64'({out_en, err_illegal, instr_ready}), 64'(3'b001));
        cyc(enc(6, 5, 1, 2, 0, 0), 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
        check("flush_accept", 64'(instr_ready), 64'(0));
        idle();
        check("flush_new_issue", 64'({out_en, opcode, dest, src1, src2}),
              64'({1'b1, 4'h6, 3'd5, 16'h0005, 16'h0003}));
        cyc(16'h0, 1'b0, 1'b0, 1'b1, 3'd3, pre[3]);
        for (int k = 0; k < 2; k++) begin
            idle();
            check("flush_no_stale", 64'(out_en), 64'(0));
        end
        cyc(16'h0, 1'b0, 1'b0, 1'b1, 3'd5, pre[5]);

        // Asynchronous reset while an instruction is held.
        cyc(enc(3, 3, 1, 2, 0, 0), 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        idle();
        cyc(enc(3, 2, 3, 1, 0, 0), 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 64'(dut_vec()), 64'(RESET_VEC));
        model_reset();
        #3 rst_n = 1'b1;
        check("ready_after_reset", 64'(instr_ready), 64'(1));
        for (int k = 0; k < 2; k++) begin
            idle();
            check("no_stale_issue", 64'(out_en), 64'(0));
        end
        cyc(enc(3, 1, 1, 1, 0, 0), 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        idle();
        check("rf_cleared", 64'({out_en, src1, src2}), 64'({1'b1, 16'h0, 16'h0}));

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            cyc(16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
